// File: rtl/avmm_stream_write_master_if.sv
// Signal bundle for avmm_stream_write_master: control, stream push side and Avalon-MM write master.
// The master modport is the block's view; slave is the view of whatever drives and observes it.
interface avmm_stream_write_master_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    control_fixed_location;
  logic [ADDR_WIDTH-1:0]   control_write_base;
  logic [ADDR_WIDTH-1:0]   control_write_length;
  logic                    control_go;
  logic                    control_done;

  logic                    user_write_buffer;
  logic [DATA_WIDTH-1:0]   user_buffer_input_data;
  logic                    user_buffer_full;

  logic [ADDR_WIDTH-1:0]   master_address;
  logic                    master_write;
  logic [DATA_WIDTH/8-1:0] master_byteenable;
  logic [DATA_WIDTH-1:0]   master_writedata;
  logic                    master_waitrequest;

  modport master (
    input  control_fixed_location, control_write_base, control_write_length, control_go,
    input  user_write_buffer, user_buffer_input_data, master_waitrequest,
    output control_done, user_buffer_full,
    output master_address, master_write, master_byteenable, master_writedata
  );

  modport slave (
    output control_fixed_location, control_write_base, control_write_length, control_go,
    output user_write_buffer, user_buffer_input_data, master_waitrequest,
    input  control_done, user_buffer_full,
    input  master_address, master_write, master_byteenable, master_writedata
  );
endinterface

// File: rtl/avmm_stream_write_master.sv
// Stream-to-memory write master: buffers pushed words in a show-ahead FIFO and writes them
// to consecutive (or one fixed) Avalon-MM addresses once a transfer is started with go.
module avmm_stream_write_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 32
) (
  input logic                        clk_clk,
  input logic                        reset_reset_n,
  avmm_stream_write_master_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [PTR_W:0]      DEPTH_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]      OCC_ONE     = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]      OCC_TWO     = (PTR_W + 1)'(2);
  localparam logic [PTR_W-1:0]    PTR_ONE     = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        occupancy;
  logic [PTR_W:0]        occ_next;
  logic                  full_q;

  logic                  done_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] words_left;
  logic                  fixed_q;

  logic                  push;
  logic                  accept;
  logic                  load_next;
  logic [DATA_WIDTH-1:0] next_data;
  logic [ADDR_WIDTH-1:0] go_base;
  logic [ADDR_WIDTH-1:0] go_words;

  assign push     = bus.user_write_buffer && !full_q;
  assign accept   = write_q && !bus.master_waitrequest;
  assign go_base  = bus.control_write_base & ~ADDR_ONE;
  assign go_words = bus.control_write_length >> 1;

  assign bus.control_done      = done_q;
  assign bus.user_buffer_full  = full_q;
  assign bus.master_write      = write_q;
  assign bus.master_address    = addr_q;
  assign bus.master_writedata  = data_q;
  assign bus.master_byteenable = '1;

  always_comb begin
    occ_next = occupancy;
    if (push && !accept) begin
      occ_next = occupancy + OCC_ONE;
    end else if (!push && accept) begin
      occ_next = occupancy - OCC_ONE;
    end
  end

  // The word on the bus stays in the FIFO until accepted, so the follow-on word is the
  // entry behind the head; it is only presented if it was already stored before this edge.
  always_comb begin
    load_next = 1'b0;
    next_data = mem[rd_ptr];
    if (state == STATE_RUN) begin
      if (accept) begin
        if (words_left > ADDR_ONE && occupancy >= OCC_TWO) begin
          load_next = 1'b1;
          next_data = mem[rd_ptr + PTR_ONE];
        end
      end else if (!write_q && occupancy != '0) begin
        load_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.user_buffer_input_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      full_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      occupancy <= occ_next;
      full_q    <= (occ_next == DEPTH_COUNT);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= STATE_IDLE;
      done_q     <= 1'b1;
      write_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      words_left <= '0;
      fixed_q    <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (bus.control_go && go_words != '0) begin
            state      <= STATE_RUN;
            done_q     <= 1'b0;
            addr_q     <= go_base;
            words_left <= go_words;
            fixed_q    <= bus.control_fixed_location;
          end
        end
        STATE_RUN: begin
          if (accept) begin
            words_left <= words_left - ADDR_ONE;
            if (!fixed_q) begin
              addr_q <= addr_q + ADDR_STEP;
            end
            if (words_left == ADDR_ONE) begin
              state  <= STATE_IDLE;
              done_q <= 1'b1;
            end
          end
          if (load_next) begin
            write_q <= 1'b1;
            data_q  <= next_data;
          end else if (accept) begin
            write_q <= 1'b0;
          end
        end
        default: begin
          state   <= STATE_IDLE;
          done_q  <= 1'b1;
          write_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_stream_write_master.sv
// Self-checking bench for avmm_stream_write_master: table of transfers plus hand-written
// sequences for full FIFO, reset mid-transfer and a random push/stall soak.
module tb_avmm_stream_write_master;

  typedef struct {
    logic [31:0] base;
    logic [31:0] length;
    logic        fixed;
    int          stall;
    int          n_push;
    int          exp_words;
    logic [31:0] step;
    logic        rego;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [15:0] model [$];
  logic [15:0] push_data;
  vec_t        vecs [7];

  avmm_stream_write_master_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

  avmm_stream_write_master #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(32),
    .FIFO_DEPTH(32)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // A push lands only if the FIFO held fewer than 32 words before the edge.
  task automatic pushWord(input logic [15:0] d);
    bus.user_write_buffer      = 1'b1;
    bus.user_buffer_input_data = d;
    if (model.size() < 32) model.push_back(d);
    tick();
    bus.user_write_buffer = 1'b0;
    checkOutput("full_flag", bus.user_buffer_full, model.size() == 32);
  endtask

  task automatic resetPulse();
    bus.control_go         = 1'b0;
    bus.user_write_buffer  = 1'b0;
    bus.master_waitrequest = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model.delete();
  endtask

  task automatic applyStimulus(input vec_t v);
    int          accepted;
    int          cycles;
    int          stall_left;
    logic        was_stalled;
    logic [31:0] addr_exp;
    logic [31:0] held_addr;
    logic [15:0] held_data;
    for (int i = 0; i < v.n_push; i++) begin
      pushWord(push_data);
      push_data = push_data + 16'h1111;
    end
    bus.control_write_base     = v.base;
    bus.control_write_length   = v.length;
    bus.control_fixed_location = v.fixed;
    bus.control_go             = 1'b1;
    tick();
    bus.control_go = 1'b0;
    checkOutput("done_after_go", bus.control_done, v.exp_words == 0);
    if (v.exp_words == 0) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("zero_len_write", bus.master_write, 0);
        checkOutput("zero_len_done", bus.control_done, 1);
        tick();
      end
      return;
    end
    addr_exp    = v.base & ~32'd1;
    accepted    = 0;
    cycles      = 0;
    stall_left  = v.stall;
    was_stalled = 1'b0;
    held_addr   = '0;
    held_data   = '0;
    while (accepted < v.exp_words && cycles < 400) begin
      if (v.rego && cycles == 1) begin
        bus.control_write_base     = 32'h900;
        bus.control_write_length   = 32'd40;
        bus.control_fixed_location = 1'b1;
        bus.control_go             = 1'b1;
      end else begin
        bus.control_go = 1'b0;
      end
      if (was_stalled) begin
        checkOutput("stall_write", bus.master_write, 1);
        checkOutput("stall_addr", bus.master_address, held_addr);
        checkOutput("stall_data", bus.master_writedata, held_data);
      end
      was_stalled = 1'b0;
      bus.master_waitrequest = 1'b0;
      if (bus.master_write) begin
        if (stall_left > 0) begin
          bus.master_waitrequest = 1'b1;
          held_addr   = bus.master_address;
          held_data   = bus.master_writedata;
          was_stalled = 1'b1;
          stall_left--;
        end else begin
          checkOutput("wr_addr", bus.master_address, addr_exp);
          checkOutput("wr_done_low", bus.control_done, 0);
          if (model.size() == 0) begin
            checkOutput("wr_nonempty", 0, 1);
          end else begin
            checkOutput("wr_data", bus.master_writedata, model.pop_front());
          end
          accepted++;
          addr_exp = addr_exp + v.step;
        end
      end
      tick();
      cycles++;
    end
    bus.control_go         = 1'b0;
    bus.master_waitrequest = 1'b0;
    checkOutput("words_accepted", accepted, v.exp_words);
    checkOutput("done_end", bus.control_done, 1);
    checkOutput("write_end", bus.master_write, 0);
    tick();
    checkOutput("write_end_hold", bus.master_write, 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          accepted;
    int          pushed;
    int          cycles;
    logic        room;
    logic        do_push;
    logic        stall;
    logic [31:0] addr_exp;
    logic [15:0] soak_data;

    tests     = 0;
    fails     = 0;
    push_data = 16'h1111;

    vecs[0] = '{32'h100,      32'd8,  1'b0, 0, 4, 4, 32'd2, 1'b0};
    vecs[1] = '{32'h20,       32'd4,  1'b1, 3, 2, 2, 32'd0, 1'b0};
    vecs[2] = '{32'h201,      32'd7,  1'b0, 1, 3, 3, 32'd2, 1'b0};
    vecs[3] = '{32'h40,       32'd0,  1'b0, 0, 2, 0, 32'd2, 1'b0};
    vecs[4] = '{32'h40,       32'd1,  1'b0, 0, 0, 0, 32'd2, 1'b0};
    vecs[5] = '{32'hFFFFFFFC, 32'd8,  1'b0, 0, 2, 4, 32'd2, 1'b0};
    vecs[6] = '{32'h300,      32'd6,  1'b0, 2, 3, 3, 32'd2, 1'b1};

    rst_n                      = 1'b0;
    bus.control_fixed_location = 1'b0;
    bus.control_write_base     = '0;
    bus.control_write_length   = '0;
    bus.control_go             = 1'b0;
    bus.user_write_buffer      = 1'b0;
    bus.user_buffer_input_data = '0;
    bus.master_waitrequest     = 1'b0;
    tick();
    tick();
    checkOutput("rst_done", bus.control_done, 1);
    checkOutput("rst_full", bus.user_buffer_full, 0);
    checkOutput("rst_write", bus.master_write, 0);
    checkOutput("rst_addr", bus.master_address, 0);
    checkOutput("rst_data", bus.master_writedata, 0);
    checkOutput("byteenable", bus.master_byteenable, 2'b11);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // Full FIFO: 33 pushes, the last one is dropped, then drain 32 words.
    for (int i = 0; i < 33; i++) begin
      pushWord(push_data);
      push_data = push_data + 16'h0101;
    end
    applyStimulus('{32'h0, 32'd64, 1'b0, 0, 0, 32, 32'd2, 1'b0});
    checkOutput("full_drained", bus.user_buffer_full, 0);
    bus.control_write_base   = 32'h80;
    bus.control_write_length = 32'd2;
    bus.control_go           = 1'b1;
    tick();
    bus.control_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("dropped_word_absent", bus.master_write, 0);
      tick();
    end
    resetPulse();

    // Reset after the 2nd accept of a 6-word transfer.
    for (int i = 0; i < 6; i++) begin
      pushWord(push_data);
      push_data = push_data + 16'h0303;
    end
    bus.control_write_base     = 32'h500;
    bus.control_write_length   = 32'd12;
    bus.control_fixed_location = 1'b0;
    bus.control_go             = 1'b1;
    tick();
    bus.control_go = 1'b0;
    accepted = 0;
    addr_exp = 32'h500;
    cycles   = 0;
    while (accepted < 2 && cycles < 50) begin
      if (bus.master_write) begin
        checkOutput("mid_addr", bus.master_address, addr_exp);
        checkOutput("mid_data", bus.master_writedata, model.pop_front());
        addr_exp = addr_exp + 32'd2;
        accepted++;
      end
      tick();
      cycles++;
    end
    checkOutput("mid_accepts", accepted, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_write", bus.master_write, 0);
    checkOutput("mid_rst_done", bus.control_done, 1);
    checkOutput("mid_rst_full", bus.user_buffer_full, 0);
    checkOutput("mid_rst_addr", bus.master_address, 0);
    checkOutput("mid_rst_data", bus.master_writedata, 0);
    tick();
    tick();
    rst_n = 1'b1;
    model.delete();
    for (int i = 0; i < 5; i++) begin
      checkOutput("post_rst_write", bus.master_write, 0);
      tick();
    end
    bus.control_write_base   = 32'h600;
    bus.control_write_length = 32'd2;
    bus.control_go           = 1'b1;
    tick();
    bus.control_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("post_rst_fifo_empty", bus.master_write, 0);
      tick();
    end
    resetPulse();

    // Soak: 10k words with random pushes and stalls, concurrent with the transfer.
    bus.control_write_base     = 32'h1000;
    bus.control_write_length   = 32'd20000;
    bus.control_fixed_location = 1'b0;
    bus.control_go             = 1'b1;
    tick();
    bus.control_go = 1'b0;
    accepted  = 0;
    pushed    = 0;
    cycles    = 0;
    addr_exp  = 32'h1000;
    soak_data = 16'h5A00;
    while (accepted < 10000 && cycles < 60000) begin
      do_push = (pushed < 10000) && ($urandom_range(1, 0) == 1);
      stall   = ($urandom_range(3, 0) == 0);
      room    = (model.size() < 32);
      bus.master_waitrequest = stall;
      if (bus.master_write) begin
        checkOutput("soak_nonempty", model.size() != 0, 1);
        if (!stall && model.size() != 0) begin
          checkOutput("soak_data", bus.master_writedata, model.pop_front());
          checkOutput("soak_addr", bus.master_address, addr_exp);
          addr_exp = addr_exp + 32'd2;
          accepted++;
        end
      end
      bus.user_write_buffer      = do_push;
      bus.user_buffer_input_data = soak_data;
      if (do_push && room) begin
        model.push_back(soak_data);
        soak_data = soak_data + 16'h0007;
        pushed++;
      end
      tick();
      cycles++;
    end
    bus.user_write_buffer  = 1'b0;
    bus.master_waitrequest = 1'b0;
    checkOutput("soak_count", accepted, 10000);
    checkOutput("soak_done", bus.control_done, 1);
    tick();
    checkOutput("soak_write_end", bus.master_write, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
